// File: rtl/ram_bb_wr_ctrl_if.sv
// Stream-in / RAM-write bus bundle for the CA/MSG RAM bank write sequencer.
// slave: the sequencer side; master: the stream source / RAM bank observer side.
interface ram_bb_wr_ctrl_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] wren;
   logic [31:0] wr_data;
   logic [4:0]  wr_addr_ca;
   logic [5:0]  wr_addr_msg;

   modport slave (
      input  s_data, s_valid,
      output s_ready, wren, wr_data, wr_addr_ca, wr_addr_msg
   );

   modport master (
      output s_data, s_valid,
      input  s_ready, wren, wr_data, wr_addr_ca, wr_addr_msg
   );
endinterface

// File: rtl/ram_bb_wr_ctrl.sv
// Write-side sequencer for the per-channel CA-code / navigation-message RAM bank.
// Parses headers from the 32-bit receive stream, streams payload words into one of
// 16 RAMs with explicit addresses, and holds the eight code-delay registers.
// Optional: define RAM_BB_WR_CHECKSUM_EN to require a trailing mod-2^32 sum word.
module ram_bb_wr_ctrl #(
   parameter logic [7:0]  SYNC      = 8'hA5,
   parameter int unsigned CA_WORDS  = 32,
   parameter int unsigned MSG_WORDS = 47,
   parameter int unsigned DELAY_W   = 10,
   parameter logic [15:0] TIMEOUT   = 16'd50000
) (
   input  logic               clk,
   input  logic               rst_n,
   ram_bb_wr_ctrl_if.slave    bus,
   output logic [DELAY_W-1:0] delay_ca0,
   output logic [DELAY_W-1:0] delay_ca1,
   output logic [DELAY_W-1:0] delay_ca2,
   output logic [DELAY_W-1:0] delay_ca3,
   output logic [DELAY_W-1:0] delay_ca4,
   output logic [DELAY_W-1:0] delay_ca5,
   output logic [DELAY_W-1:0] delay_ca6,
   output logic [DELAY_W-1:0] delay_ca7,
   output logic               busy,
   output logic [15:0]        load_done,
   output logic [7:0]         err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE
`ifdef RAM_BB_WR_CHECKSUM_EN
      , ST_CHECK
`endif
   } state_t;

   state_t state, state_nx;

   logic [3:0]  tgt;
   logic [5:0]  cnt;
   logic [5:0]  cnt_last;
   logic [15:0] idle_cnt;
   logic [DELAY_W-1:0] delay_q [8];

   logic       accept;
   logic       hdr_sync;
   logic [1:0] hdr_cmd;
   logic [2:0] hdr_ch;
   logic       start_load;
   logic       set_delay;
   logic       wr_word;
   logic       err_inc;
   logic       stall;
   logic       timed_out;

`ifdef RAM_BB_WR_CHECKSUM_EN
   logic [31:0] sum;
`endif

   assign accept    = bus.s_valid & bus.s_ready;
   assign hdr_sync  = (bus.s_data[31:24] == SYNC);
   assign hdr_cmd   = bus.s_data[23:22];
   assign hdr_ch    = bus.s_data[21:19];
   assign timed_out = (idle_cnt == TIMEOUT - 16'd1);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state decode and per-cycle action strobes.
   always_comb begin
      state_nx   = state;
      start_load = 1'b0;
      set_delay  = 1'b0;
      wr_word    = 1'b0;
      err_inc    = 1'b0;
      stall      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (!hdr_sync || hdr_cmd == 2'b11) begin
                  err_inc = 1'b1;
               end else if (hdr_cmd == 2'b10) begin
                  set_delay = 1'b1;
               end else begin
                  start_load = 1'b1;
                  state_nx   = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (accept) begin
               wr_word = 1'b1;
               if (cnt == cnt_last) begin
`ifdef RAM_BB_WR_CHECKSUM_EN
                  state_nx = ST_CHECK;
`else
                  state_nx = ST_DONE;
`endif
               end
            end else begin
               stall = 1'b1;
               if (timed_out) begin
                  err_inc  = 1'b1;
                  state_nx = ST_IDLE;
               end
            end
         end
`ifdef RAM_BB_WR_CHECKSUM_EN
         ST_CHECK: begin
            if (accept) begin
               if (bus.s_data == sum) begin
                  state_nx = ST_DONE;
               end else begin
                  err_inc  = 1'b1;
                  state_nx = ST_IDLE;
               end
            end else begin
               stall = 1'b1;
               if (timed_out) begin
                  err_inc  = 1'b1;
                  state_nx = ST_IDLE;
               end
            end
         end
`endif
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Handshake and busy are registered from the next state so both are clean at reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.s_ready <= 1'b0;
         busy        <= 1'b0;
      end else begin
         bus.s_ready <= (state_nx != ST_DONE);
         busy        <= (state_nx != ST_IDLE);
      end
   end

   // Load bookkeeping: target, word counter, stall timer and running sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt      <= '0;
         cnt      <= '0;
         cnt_last <= '0;
         idle_cnt <= '0;
`ifdef RAM_BB_WR_CHECKSUM_EN
         sum      <= '0;
`endif
      end else if (start_load) begin
         tgt      <= {hdr_cmd[0], hdr_ch};
         cnt      <= '0;
         cnt_last <= hdr_cmd[0] ? 6'(MSG_WORDS - 1) : 6'(CA_WORDS - 1);
         idle_cnt <= '0;
`ifdef RAM_BB_WR_CHECKSUM_EN
         sum      <= '0;
`endif
      end else begin
         if (wr_word) begin
            cnt <= cnt + 6'd1;
`ifdef RAM_BB_WR_CHECKSUM_EN
            sum <= sum + bus.s_data;
`endif
         end
         if (accept)     idle_cnt <= '0;
         else if (stall) idle_cnt <= idle_cnt + 16'd1;
      end
   end

   // RAM write port: one-hot strobe, data and per-type address, 1 clk after acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.wren        <= '0;
         bus.wr_data     <= '0;
         bus.wr_addr_ca  <= '0;
         bus.wr_addr_msg <= '0;
      end else begin
         bus.wren <= '0;
         if (wr_word) begin
            bus.wren    <= 16'h0001 << tgt;
            bus.wr_data <= bus.s_data;
            if (tgt[3]) bus.wr_addr_msg <= cnt;
            else        bus.wr_addr_ca  <= cnt[4:0];
         end
      end
   end

   // Sticky per-RAM loaded flags: cleared when a load starts, set only on DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_done <= '0;
      end else if (start_load) begin
         load_done[{hdr_cmd[0], hdr_ch}] <= 1'b0;
      end else if (state == ST_DONE) begin
         load_done[tgt] <= 1'b1;
      end
   end

   // Saturating protocol error counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          err_cnt <= '0;
      else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
   end

   // Per-channel code-delay registers, written only by the set-delay command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 8; i++) delay_q[i] <= '0;
      end else if (set_delay) begin
         delay_q[hdr_ch] <= bus.s_data[DELAY_W-1:0];
      end
   end

   assign delay_ca0 = delay_q[0];
   assign delay_ca1 = delay_q[1];
   assign delay_ca2 = delay_q[2];
   assign delay_ca3 = delay_q[3];
   assign delay_ca4 = delay_q[4];
   assign delay_ca5 = delay_q[5];
   assign delay_ca6 = delay_q[6];
   assign delay_ca7 = delay_q[7];

endmodule

// File: tb/tb_ram_bb_wr_ctrl.sv
// Self-checking bench for ram_bb_wr_ctrl: table-driven IDLE commands, scoreboarded
// RAM writes, and hand sequences for timeout, saturation, reset and checksum.
module tb_ram_bb_wr_ctrl;
   localparam logic [15:0] TO = 16'd300;

   logic clk = 1'b0;
   logic rst_n;
   logic [9:0]  dly [8];
   logic        busy;
   logic [15:0] load_done;
   logic [7:0]  err_cnt;

   ram_bb_wr_ctrl_if bus ();

   ram_bb_wr_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .delay_ca0(dly[0]), .delay_ca1(dly[1]), .delay_ca2(dly[2]), .delay_ca3(dly[3]),
      .delay_ca4(dly[4]), .delay_ca5(dly[5]), .delay_ca6(dly[6]), .delay_ca7(dly[7]),
      .busy(busy), .load_done(load_done), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] wren;
      logic [31:0] data;
      logic [4:0]  ca;
      logic [5:0]  msg;
   } wr_t;

   typedef struct {
      logic [31:0] word;
      bit          is_dly;
      int          ch;
      logic [9:0]  val;
      logic [7:0]  err;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   wr_t sbq[$];
   logic [4:0]  m_ca;
   logic [5:0]  m_msg;
   logic [9:0]  m_dly [8];
   logic [15:0] m_ld;
   int          m_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Scoreboard: every wren pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.wren != 16'h0) begin
         pulses++;
         if (sbq.size() == 0) begin
            chk("wren_unexpected", {16'h0, bus.wren}, 32'h0);
         end else begin
            wr_t e;
            e = sbq.pop_front();
            chk("wren", {16'h0, bus.wren}, {16'h0, e.wren});
            chk("wr_data", bus.wr_data, e.data);
            chk("wr_addr_ca", {27'h0, bus.wr_addr_ca}, {27'h0, e.ca});
            chk("wr_addr_msg", {26'h0, bus.wr_addr_msg}, {26'h0, e.msg});
         end
      end
   end

   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      @(negedge clk);
      bus.s_data  = w;
      bus.s_valid = 1'b1;
      while (!bus.s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.s_ready) chk("s_ready_wait", 32'h0, 32'h1);
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic check_reset();
      chk("rst_s_ready", {31'h0, bus.s_ready}, 32'h0);
      chk("rst_wren", {16'h0, bus.wren}, 32'h0);
      chk("rst_wr_data", bus.wr_data, 32'h0);
      chk("rst_addr_ca", {27'h0, bus.wr_addr_ca}, 32'h0);
      chk("rst_addr_msg", {26'h0, bus.wr_addr_msg}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_load_done", {16'h0, load_done}, 32'h0);
      chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
      for (int j = 0; j < 8; j++) chk("rst_delay", {22'h0, dly[j]}, 32'h0);
   endtask

   task automatic do_reset();
      bus.s_valid = 1'b0;
      bus.s_data  = 32'h0;
      rst_n = 1'b0;
      #1;
      check_reset();
      sbq.delete();
      m_ca = '0; m_msg = '0; m_ld = '0; m_err = 0;
      for (int j = 0; j < 8; j++) m_dly[j] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_delays();
      for (int j = 0; j < 8; j++) chk("delay", {22'h0, dly[j]}, {22'h0, m_dly[j]});
   endtask

   // idx: 0-7 CA ch, 8-15 MSG ch. full=0 sends only n words and leaves the load open.
   task automatic do_load(input int idx, input int n, input logic [31:0] base,
                          input bit full, input bit good_sum);
      logic [31:0] w, sum;
      wr_t e;
      logic [31:0] hdr;
      hdr = {8'hA5, (idx >= 8) ? 2'b01 : 2'b00, 3'(idx % 8), 19'h0};
      send(hdr);
      m_ld[idx] = 1'b0;
      chk("busy_start", {31'h0, busy}, 32'h1);
      chk("load_done_clr", {16'h0, load_done}, {16'h0, m_ld});
      sum = 32'h0;
      for (int k = 0; k < n; k++) begin
         w = (k == 3 && base != 0) ? 32'hA500_0000 : base + 32'(k);
         e.wren = 16'h0001 << idx;
         e.data = w;
         if (idx >= 8) m_msg = 6'(k);
         else          m_ca  = 5'(k);
         e.ca  = m_ca;
         e.msg = m_msg;
         sbq.push_back(e);
         send(w);
         sum = sum + w;
      end
      if (full) begin
`ifdef RAM_BB_WR_CHECKSUM_EN
         send(good_sum ? sum : sum ^ 32'h1);
         if (good_sum) m_ld[idx] = 1'b1;
         else          m_err = (m_err < 255) ? m_err + 1 : 255;
`else
         m_ld[idx] = 1'b1;
`endif
         @(posedge clk);
         #1;
         chk("busy_end", {31'h0, busy}, 32'h0);
         chk("load_done", {16'h0, load_done}, {16'h0, m_ld});
         chk("err_cnt_load", {24'h0, err_cnt}, 32'(m_err));
      end
   endtask

   vec_t tbl[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{word: 32'hA5B8_03FF, is_dly: 1, ch: 7, val: 10'h3FF, err: 8'd0};
      tbl[1] = '{word: 32'hA590_0155, is_dly: 1, ch: 2, val: 10'h155, err: 8'd0};
      tbl[2] = '{word: 32'h1234_5678, is_dly: 0, ch: 0, val: 10'h0,   err: 8'd1};
      tbl[3] = '{word: 32'hA5C0_0000, is_dly: 0, ch: 0, val: 10'h0,   err: 8'd2};
      tbl[4] = '{word: 32'h5AB8_0001, is_dly: 0, ch: 0, val: 10'h0,   err: 8'd3};

      bus.s_valid = 1'b0;
      bus.s_data  = 32'h0;
      rst_n = 1'b1;
      #3;
      do_reset();

      // IDLE command table
      for (int i = 0; i < 5; i++) begin
         send(tbl[i].word);
         if (tbl[i].is_dly) m_dly[tbl[i].ch] = tbl[i].val;
         chk("tbl_err_cnt", {24'h0, err_cnt}, {24'h0, tbl[i].err});
         chk("tbl_wren", {16'h0, bus.wren}, 32'h0);
         chk("tbl_busy", {31'h0, busy}, 32'h0);
         check_delays();
      end
      m_err = 3;

      // CA load ch0 with words 0..31
      do_reset();
      pulses = 0;
      do_load(0, 32, 32'h0, 1, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("ca0_pulses", 32'(pulses), 32'd32);
      chk("ca0_sbq_empty", 32'(sbq.size()), 32'd0);
      chk("ca0_load_done", {16'h0, load_done}, 32'h0000_0001);

      // MSG ch4 then CA ch1; delay set beforehand must survive the loads
      do_reset();
      send(32'hA590_0123);
      m_dly[2] = 10'h123;
      pulses = 0;
      do_load(12, 47, $urandom | 32'h1, 1, 1);
      do_load(1, 32, $urandom | 32'h1, 1, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("mc_pulses", 32'(pulses), 32'd79);
      chk("mc_load_done", {16'h0, load_done}, 32'h0000_1002);
      check_delays();

      // Stall timeout on CA ch3 after 10 words
      pulses = 0;
      do_load(3, 10, 32'h0000_0100, 0, 1);
      repeat (int'(TO) + 3) @(posedge clk);
      #1;
      m_err = m_err + 1;
      chk("to_pulses", 32'(pulses), 32'd10);
      chk("to_busy", {31'h0, busy}, 32'h0);
      chk("to_s_ready", {31'h0, bus.s_ready}, 32'h1);
      chk("to_err_cnt", {24'h0, err_cnt}, 32'(m_err));
      chk("to_load_done", {16'h0, load_done}, {16'h0, m_ld});
      send(32'hA598_02AA);
      m_dly[3] = 10'h2AA;
      check_delays();
      chk("to_idle_wren", {16'h0, bus.wren}, 32'h0);
      chk("to_sbq_empty", 32'(sbq.size()), 32'd0);

      // Error counter saturation
      for (int i = 0; i < 256; i++) send(32'h0000_0000);
      chk("err_sat", {24'h0, err_cnt}, 32'd255);

`ifdef RAM_BB_WR_CHECKSUM_EN
      // Checksum: good sum then bad sum
      do_reset();
      do_load(0, 32, $urandom | 32'h1, 1, 1);
      do_load(2, 32, $urandom | 32'h1, 1, 0);
      chk("cs_load_done", {16'h0, load_done}, 32'h0000_0001);
      chk("cs_err_cnt", {24'h0, err_cnt}, 32'd1);
`endif

      // Reset in the middle of a load
      do_reset();
      send(32'hA588_0011);
      m_dly[1] = 10'h011;
      do_load(5, 5, 32'h0000_0200, 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset();
      sbq.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_mid_pulses", 32'(pulses), 32'd0);
      chk("rst_mid_busy", {31'h0, busy}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
